mem_request_master: RTL and testbench

//  CPU-side initiator for the 64-bit read/write/done_n memory port served by the RAM controller.

---
 rtl/mem_request_master_if.sv | 26 ++
 rtl/mem_request_master.sv | 89 ++++++++
 tb/tb_mem_request_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_request_master_if.sv
// CPU request/response channel plus the control half of the 64-bit read/write/done_n memory port.
// The bidirectional data bus stays a plain inout on the master so tristate resolution stays simple.
interface mem_request_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic [63:0] address;
    logic        read;
    logic        write;
    logic        done_n;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, done_n,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, address, read, write
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, done_n,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, address, read, write
    );
endinterface

// File: rtl/mem_request_master.sv
// CPU-side initiator: one four-phase read/write/done_n transaction per accepted request,
// answered with a single-cycle response pulse (data or error).
module mem_request_master #(
    parameter int TIMEOUT     = 1024,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetin,
    mem_request_master_if.master  bus,
    inout  wire  [63:0]           data
);
    typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [63:0]    wdata_q;
    logic           accept;
    logic           misaligned;
    logic           timeout_hit;

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && (state == IDLE);
    assign misaligned    = ALIGN_CHECK && (bus.req_addr[2:0] != 3'b000);
    assign timeout_hit   = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    // The write strobe register doubles as the bus driver enable, so data can never be
    // driven outside a store and is released on the same edge the strobe drops.
    assign data = bus.write ? wdata_q : {64{1'bz}};

    always_ff @(posedge clock) begin
        if (!resetin) begin
            state         <= IDLE;
            cnt           <= '0;
            wdata_q       <= '0;
            bus.address   <= '0;
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_error <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_error <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else begin
                            bus.address <= bus.req_addr;
                            wdata_q     <= bus.req_wdata;
                            bus.read    <= !bus.req_write;
                            bus.write   <= bus.req_write;
                            cnt         <= '0;
                            state       <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // An ack on the timeout cycle still wins.
                    if (!bus.done_n) begin
                        bus.rsp_rdata <= bus.read ? data : 64'd0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_error <= 1'b0;
                        bus.read      <= 1'b0;
                        bus.write     <= 1'b0;
                        state         <= RELEASE;
                    end else if (timeout_hit) begin
                        bus.rsp_rdata <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_error <= 1'b1;
                        bus.read      <= 1'b0;
                        bus.write     <= 1'b0;
                        state         <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (bus.done_n) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_request_master.sv
// Randomized transaction bench: a transaction-level model predicts response, latency and
// bus behaviour; a simple controller model acks after a chosen delay or never.
module tb_mem_request_master;
    localparam int TO = 16;

    logic clock   = 1'b0;
    logic resetin = 1'b0;
    always #5 clock = ~clock;

    mem_request_master_if bus();
    wire  [63:0] data;
    logic [63:0] ctl_rdata = '0;
    logic [63:0] probe     = 64'h0123_4567_89AB_CDEF;

    // Controller returns load data under read; otherwise a probe pattern shows whether
    // the master has released the bus.
    assign data = bus.write ? {64{1'bz}} : (bus.read ? ctl_rdata : probe);

    mem_request_master #(.TIMEOUT(TO), .ALIGN_CHECK(1'b1)) dut (
        .clock  (clock),
        .resetin(resetin),
        .bus    (bus.master),
        .data   (data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
        int          lat;
        logic        bus_used;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected outcome of one request given the controller's ack delay d (>= TO: never acks).
    function automatic exp_t model(input logic wr, input logic [63:0] addr,
                                   input logic [63:0] rd, input int d);
        exp_t e;
        if (addr[2:0] != 3'b000) begin
            e.err = 1'b1; e.rdata = '0; e.lat = 0; e.bus_used = 1'b0;
        end else begin
            e.bus_used = 1'b1;
            e.err      = (d >= TO);
            e.lat      = (d < TO) ? d : TO - 1;
            e.rdata    = (wr || e.err) ? 64'd0 : rd;
        end
        return e;
    endfunction

    // Starts and ends just after a negedge.
    task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rd, input int d, input int h);
        exp_t e;
        e = model(wr, addr, rd, d);
        probe = ~wdata ^ {$urandom, $urandom} & 64'hFFFF_0000_0000_0000;
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        ctl_rdata     = rd;
        @(posedge clock); @(negedge clock);
        bus.req_valid = 1'b0;
        if (!e.bus_used) begin
            chk("misalign_valid", bus.rsp_valid, 1);
            chk("misalign_error", bus.rsp_error, 1);
            chk("misalign_rdata", bus.rsp_rdata, 0);
            chk("misalign_strobes", {bus.read, bus.write}, 0);
            chk("misalign_ready", bus.req_ready, 1);
            @(negedge clock);
            chk("misalign_pulse", bus.rsp_valid, 0);
            chk("misalign_quiet", {bus.read, bus.write}, 0);
            return;
        end
        chk("strobe_rise", {bus.read, bus.write}, wr ? 2'b01 : 2'b10);
        chk("address", bus.address, addr);
        chk("req_ready_busy", bus.req_ready, 0);
        for (int j = 0; j <= e.lat; j++) begin
            bus.done_n = (j >= d) ? 1'b0 : 1'b1;
            if (wr) chk("wdata_on_bus", data, wdata);
            chk("no_early_rsp", bus.rsp_valid, 0);
            chk("strobe_held", {bus.read, bus.write}, wr ? 2'b01 : 2'b10);
            @(posedge clock); @(negedge clock);
        end
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_error", bus.rsp_error, e.err);
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("strobe_drop", {bus.read, bus.write}, 0);
        chk("bus_released", data, probe);
        chk("ready_release", bus.req_ready, 0);
        if (!e.err) begin
            for (int i = 0; i < h; i++) begin
                @(posedge clock); @(negedge clock);
                chk("ready_hold", bus.req_ready, 0);
                chk("rsp_single", bus.rsp_valid, 0);
                chk("strobe_low_hold", {bus.read, bus.write}, 0);
            end
        end
        bus.done_n = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("ready_back", bus.req_ready, 1);
        chk("rsp_done", bus.rsp_valid, 0);
        chk("rdata_held", bus.rsp_rdata, e.rdata);
        chk("address_held", bus.address, addr);
    endtask

    task automatic reset_mid_wait();
        probe = 64'h5555_AAAA_3333_CCCC;
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr  = 64'h2000; bus.req_wdata = 64'hFEED_FACE_CAFE_BEEF;
        @(posedge clock); @(negedge clock);
        bus.req_valid = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("pre_reset_write", bus.write, 1);
        resetin = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("rst_strobes", {bus.read, bus.write}, 0);
        chk("rst_address", bus.address, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_error", bus.rsp_error, 0);
        chk("rst_data_z", data, probe);
        resetin = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("post_rst_ready", bus.req_ready, 1);
        chk("post_rst_no_rsp", bus.rsp_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] a, w, r;
        int          d, h;
        bus.req_valid = 1'b0; bus.req_write = 1'b0;
        bus.req_addr  = '0;   bus.req_wdata = '0;
        bus.done_n    = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_strobes", {bus.read, bus.write}, 0);
        chk("reset_address", bus.address, 0);
        chk("reset_rsp", {bus.rsp_valid, bus.rsp_error}, 0);
        chk("reset_rdata", bus.rsp_rdata, 0);
        chk("reset_data_z", data, probe);
        resetin = 1'b1;
        @(negedge clock);

        run_txn(1'b0, 64'h40,   64'h0, 64'hDEAD_BEEF_0123_4567, 3, 0);
        run_txn(1'b1, 64'h1000, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 2, 0);
        run_txn(1'b0, 64'h43,   64'h0, 64'h1111, 0, 0);
        run_txn(1'b0, 64'h80,   64'h0, 64'h2222, 1000, 0);
        run_txn(1'b0, 64'h88,   64'h0, 64'h3333_4444, TO - 1, 0);
        run_txn(1'b1, 64'h90,   64'h1234, 64'h0, 0, 5);
        run_txn(1'b0, 64'h98,   64'h0, 64'h9999_8888_7777_6666, 0, 0);

        for (int n = 0; n < 40; n++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(3) != 0) a[2:0] = 3'b000;
            w = {$urandom, $urandom};
            r = {$urandom, $urandom};
            d = $urandom_range(TO + 4);
            h = $urandom_range(4);
            run_txn(1'($urandom_range(1)), a, w, r, d, h);
        end

        reset_mid_wait();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
